// File: rtl/sargantana_itag_ctrl.sv
// Instruction-cache tag-array sequencer: shares one tag-memory port between lookups,
// refills and an invalidate-all sweep. Define ITAG_CTRL_LFSR_EN for LFSR victim choice.
module sargantana_itag_ctrl #(
    parameter int ICACHE_N_WAY   = 4,
    parameter int TAG_DEPTH      = 64,
    parameter int TAG_ADDR_WIDHT = $clog2(TAG_DEPTH),
    parameter int TAG_WIDHT      = 20
) (
    input  logic                                   clk_i,
    input  logic                                   rst_i,
    input  logic                                   lookup_valid_i,
    output logic                                   lookup_ready_o,
    input  logic [TAG_ADDR_WIDHT-1:0]              lookup_addr_i,
    input  logic [TAG_WIDHT-1:0]                   lookup_tag_i,
    output logic                                   lookup_rvalid_o,
    output logic                                   lookup_hit_o,
    output logic [ICACHE_N_WAY-1:0]                lookup_hit_way_o,
    input  logic                                   refill_valid_i,
    output logic                                   refill_ready_o,
    input  logic [TAG_ADDR_WIDHT-1:0]              refill_addr_i,
    input  logic [TAG_WIDHT-1:0]                   refill_tag_i,
    output logic                                   refill_done_o,
    output logic [ICACHE_N_WAY-1:0]                refill_way_o,
    input  logic                                   flush_i,
    output logic                                   flush_busy_o,
    output logic                                   flush_done_o,
    output logic [ICACHE_N_WAY-1:0]                mem_req_o,
    output logic                                   mem_we_o,
    output logic                                   mem_vbit_o,
    output logic [TAG_WIDHT-1:0]                   mem_data_o,
    output logic [TAG_ADDR_WIDHT-1:0]              mem_addr_o,
    input  logic [ICACHE_N_WAY-1:0][TAG_WIDHT-1:0] mem_tag_way_i,
    input  logic [ICACHE_N_WAY-1:0]                mem_vbit_i
);
    localparam int WAY_W = (ICACHE_N_WAY > 1) ? $clog2(ICACHE_N_WAY) : 1;

    typedef enum logic [1:0] {IDLE, RF_RD, RF_WR, FLUSH} state_t;
    state_t state, state_nxt;

    logic                      flush_pending;
    logic                      flush_req;
    logic                      flush_last;
    logic [TAG_ADDR_WIDHT-1:0] flush_cnt;
    logic [TAG_ADDR_WIDHT-1:0] refill_addr;
    logic [TAG_WIDHT-1:0]      refill_tag;
    logic [TAG_WIDHT-1:0]      lookup_tag;
    logic [WAY_W-1:0]          repl_idx;
    logic [ICACHE_N_WAY-1:0]   victim;
    logic                      all_valid;

    assign flush_req  = flush_i | flush_pending;
    assign flush_last = (flush_cnt == TAG_ADDR_WIDHT'(TAG_DEPTH - 1));

    // Ready is gated by reset so every output reads zero while reset is held.
    assign refill_ready_o = !rst_i && (state == IDLE) && !flush_req && refill_valid_i;
    assign lookup_ready_o = !rst_i && (state == IDLE) && !flush_req && !refill_valid_i
                            && lookup_valid_i;

    assign refill_done_o = (state == RF_WR);
    assign refill_way_o  = refill_done_o ? victim : '0;
    assign flush_done_o  = (state == FLUSH) && flush_last;
    assign flush_busy_o  = flush_pending | (state == FLUSH);

`ifdef ITAG_CTRL_LFSR_EN
    logic [7:0] lfsr;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) lfsr <= 8'h01;
        else       lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end

    assign repl_idx = lfsr[WAY_W-1:0];
`else
    logic [WAY_W-1:0] repl_ptr;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            repl_ptr <= '0;
        else if (state == RF_WR && all_valid)
            repl_ptr <= (repl_ptr == WAY_W'(ICACHE_N_WAY - 1)) ? '0 : repl_ptr + 1'b1;
    end

    assign repl_idx = repl_ptr;
`endif

    // Lowest invalid way wins; descending scan lets the lowest index overwrite.
    always_comb begin
        victim    = '0;
        all_valid = &mem_vbit_i;
        for (int w = ICACHE_N_WAY - 1; w >= 0; w--)
            if (!mem_vbit_i[w]) victim = ICACHE_N_WAY'(1) << w;
        if (all_valid) begin
            victim           = '0;
            victim[repl_idx] = 1'b1;
        end
    end

    for (genvar w = 0; w < ICACHE_N_WAY; w++) begin : g_hit
        assign lookup_hit_way_o[w] = lookup_rvalid_o & mem_vbit_i[w]
                                     & (mem_tag_way_i[w] == lookup_tag);
    end
    assign lookup_hit_o = |lookup_hit_way_o;

    always_comb begin
        state_nxt  = state;
        mem_req_o  = '0;
        mem_we_o   = 1'b0;
        mem_vbit_o = 1'b0;
        mem_data_o = '0;
        mem_addr_o = '0;
        case (state)
            IDLE: begin
                if (flush_req)
                    state_nxt = FLUSH;
                else if (refill_ready_o)
                    state_nxt = RF_RD;
                else if (lookup_ready_o) begin
                    mem_req_o  = '1;
                    mem_addr_o = lookup_addr_i;
                end
            end
            RF_RD: begin
                mem_req_o  = '1;
                mem_addr_o = refill_addr;
                state_nxt  = RF_WR;
            end
            RF_WR: begin
                mem_req_o  = victim;
                mem_we_o   = 1'b1;
                mem_vbit_o = 1'b1;
                mem_data_o = refill_tag;
                mem_addr_o = refill_addr;
                state_nxt  = flush_req ? FLUSH : IDLE;
            end
            FLUSH: begin
                mem_req_o  = '1;
                mem_we_o   = 1'b1;
                mem_addr_o = flush_cnt;
                if (flush_last) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state           <= IDLE;
            flush_pending   <= 1'b0;
            flush_cnt       <= '0;
            refill_addr     <= '0;
            refill_tag      <= '0;
            lookup_tag      <= '0;
            lookup_rvalid_o <= 1'b0;
        end else begin
            state           <= state_nxt;
            lookup_rvalid_o <= lookup_ready_o;
            if (lookup_ready_o) lookup_tag <= lookup_tag_i;
            if (refill_ready_o) begin
                refill_addr <= refill_addr_i;
                refill_tag  <= refill_tag_i;
            end
            // Requests arriving mid-sweep are dropped; the sweep already covers them.
            if (state == FLUSH) begin
                flush_cnt <= flush_last ? '0 : flush_cnt + 1'b1;
                if (flush_last) flush_pending <= 1'b0;
            end else if (flush_i) begin
                flush_pending <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sargantana_itag_ctrl.sv
// Bench for sargantana_itag_ctrl: tag memory model, cache-content reference model
// checked every cycle, directed scenarios with literal expectations, then random traffic.
module tb_sargantana_itag_ctrl;
    localparam int N     = 4;
    localparam int DEPTH = 64;
    localparam int AW    = 6;
    localparam int TW    = 20;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic lookup_valid = 1'b0, lookup_ready, lookup_rvalid, lookup_hit;
    logic [AW-1:0] lookup_addr = '0;
    logic [TW-1:0] lookup_tag = '0;
    logic [N-1:0] lookup_hit_way;
    logic refill_valid = 1'b0, refill_ready, refill_done;
    logic [AW-1:0] refill_addr = '0;
    logic [TW-1:0] refill_tag = '0;
    logic [N-1:0] refill_way;
    logic flush = 1'b0, flush_busy, flush_done;
    logic [N-1:0] mem_req;
    logic mem_we, mem_vbit;
    logic [TW-1:0] mem_data;
    logic [AW-1:0] mem_addr;
    logic [N-1:0][TW-1:0] rd_tag;
    logic [N-1:0] rd_v;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sargantana_itag_ctrl #(.ICACHE_N_WAY(N), .TAG_DEPTH(DEPTH), .TAG_ADDR_WIDHT(AW),
                           .TAG_WIDHT(TW)) dut (
        .clk_i(clk), .rst_i(rst),
        .lookup_valid_i(lookup_valid), .lookup_ready_o(lookup_ready),
        .lookup_addr_i(lookup_addr), .lookup_tag_i(lookup_tag),
        .lookup_rvalid_o(lookup_rvalid), .lookup_hit_o(lookup_hit),
        .lookup_hit_way_o(lookup_hit_way),
        .refill_valid_i(refill_valid), .refill_ready_o(refill_ready),
        .refill_addr_i(refill_addr), .refill_tag_i(refill_tag),
        .refill_done_o(refill_done), .refill_way_o(refill_way),
        .flush_i(flush), .flush_busy_o(flush_busy), .flush_done_o(flush_done),
        .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_vbit_o(mem_vbit),
        .mem_data_o(mem_data), .mem_addr_o(mem_addr),
        .mem_tag_way_i(rd_tag), .mem_vbit_i(rd_v)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Tag memory with registered read data, driven only by the DUT's mem_* outputs.
    logic [TW-1:0] btag [DEPTH][N];
    logic          bval [DEPTH][N];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < DEPTH; s++)
                for (int w = 0; w < N; w++) begin
                    bval[s][w] <= 1'b0;
                    btag[s][w] <= '0;
                end
            rd_v   <= '0;
            rd_tag <= '0;
        end else begin
            for (int w = 0; w < N; w++)
                if (mem_req[w]) begin
                    if (mem_we) begin
                        bval[mem_addr][w] <= mem_vbit;
                        btag[mem_addr][w] <= mem_data;
                    end else begin
                        rd_v[w]   <= bval[mem_addr][w];
                        rd_tag[w] <= btag[mem_addr][w];
                    end
                end
        end
    end

    // Reference model: cache contents plus refill/sweep progress, evaluated at negedge.
    logic          mv [DEPTH][N];
    logic [TW-1:0] mt [DEPTH][N];
    int            rf_phase, sweep_idx, ptr;
    bit            pend, lk_prev;
    logic [AW-1:0] lk_addr, rf_addr_m;
    logic [TW-1:0] lk_tag, rf_tag_m;

    initial forever begin
        logic e_lr, e_rr, e_busy, e_rv, e_done, e_fd, e_we, e_vb, idle, freq, allv, was_sweep;
        logic [N-1:0] e_hw, vic, e_req;
        logic [TW-1:0] e_data;
        logic [AW-1:0] e_addr;
        @(negedge clk);
        e_lr = 0; e_rr = 0; e_busy = 0; e_rv = 0; e_done = 0; e_fd = 0;
        e_we = 0; e_vb = 0; e_hw = '0; vic = '0; e_req = '0; e_data = '0; e_addr = '0;
        idle = 0; freq = 0; allv = 0;
        if (rst) begin
            for (int s = 0; s < DEPTH; s++)
                for (int w = 0; w < N; w++) begin
                    mv[s][w] = 1'b0;
                    mt[s][w] = '0;
                end
            rf_phase = 0; sweep_idx = -1; ptr = 0; pend = 0; lk_prev = 0;
            lk_addr = '0; lk_tag = '0; rf_addr_m = '0; rf_tag_m = '0;
        end else begin
            idle   = (sweep_idx < 0) && (rf_phase == 0);
            freq   = flush || pend;
            e_rr   = idle && !freq && refill_valid;
            e_lr   = idle && !freq && !refill_valid && lookup_valid;
            e_busy = pend || (sweep_idx >= 0);
            e_rv   = lk_prev;
            for (int w = 0; w < N; w++)
                e_hw[w] = lk_prev && mv[lk_addr][w] && (mt[lk_addr][w] == lk_tag);
            if (rf_phase == 2) begin
                allv = 1;
                for (int w = N - 1; w >= 0; w--)
                    if (!mv[rf_addr_m][w]) begin
                        allv = 0;
                        vic  = '0;
                        vic[w] = 1'b1;
                    end
                if (allv) vic = N'(1) << ptr;
            end
            e_done = (rf_phase == 2);
            e_fd   = (sweep_idx == DEPTH - 1);
            if (sweep_idx >= 0) begin
                e_req = '1; e_we = 1; e_addr = AW'(sweep_idx);
            end else if (rf_phase == 1) begin
                e_req = '1; e_addr = rf_addr_m;
            end else if (rf_phase == 2) begin
                e_req = vic; e_we = 1; e_vb = 1; e_data = rf_tag_m; e_addr = rf_addr_m;
            end else if (e_lr) begin
                e_req = '1; e_addr = lookup_addr;
            end
        end
        check("lookup_ready", lookup_ready, e_lr);
        check("refill_ready", refill_ready, e_rr);
        check("lookup_rvalid", lookup_rvalid, e_rv);
        check("lookup_hit_way", lookup_hit_way, e_hw);
        check("lookup_hit", lookup_hit, |e_hw);
        check("refill_done", refill_done, e_done);
        check("refill_way", refill_way, vic);
        check("flush_busy", flush_busy, e_busy);
        check("flush_done", flush_done, e_fd);
        check("mem_req", mem_req, e_req);
        check("mem_we", mem_we, e_we);
        check("mem_vbit", mem_vbit, e_vb);
        check("mem_data", mem_data, e_data);
        check("mem_addr", mem_addr, e_addr);
        if (!rst) begin
            was_sweep = (sweep_idx >= 0);
            if (rf_phase == 2) begin
                for (int w = 0; w < N; w++)
                    if (vic[w]) begin
                        mv[rf_addr_m][w] = 1'b1;
                        mt[rf_addr_m][w] = rf_tag_m;
                    end
                if (allv) ptr = (ptr + 1) % N;
                rf_phase = 0;
                if (freq) sweep_idx = 0;
            end else if (rf_phase == 1) begin
                rf_phase = 2;
            end else if (sweep_idx >= 0) begin
                if (sweep_idx == DEPTH - 1) begin
                    for (int s = 0; s < DEPTH; s++)
                        for (int w = 0; w < N; w++) mv[s][w] = 1'b0;
                    sweep_idx = -1;
                    pend = 0;
                end else begin
                    sweep_idx++;
                end
            end else if (freq) begin
                sweep_idx = 0;
            end else if (refill_valid) begin
                rf_phase = 1; rf_addr_m = refill_addr; rf_tag_m = refill_tag;
            end
            if (flush && !was_sweep) pend = 1;
            lk_prev = e_lr;
            if (e_lr) begin
                lk_addr = lookup_addr;
                lk_tag  = lookup_tag;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_refill(input logic [AW-1:0] a, input logic [TW-1:0] t,
                             output logic [N-1:0] way);
        refill_valid = 1; refill_addr = a; refill_tag = t;
        @(negedge clk);
        check("refill_accept", refill_ready, 1);
        tick();
        refill_valid = 0;
        @(negedge clk);
        check("refill_rd_not_ready", refill_ready, 0);
        tick();
        @(negedge clk);
        check("refill_done_t2", refill_done, 1);
        way = refill_way;
        tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [N-1:0] way;
        logic [N-1:0] exp_way [5];
        int n, bad;
        exp_way = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

        // Reset: outputs stay zero even with a lookup request present.
        lookup_valid = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_lookup_ready", lookup_ready, 0);
        check("reset_mem_req", mem_req, 0);
        @(posedge clk); #1;
        rst = 0; lookup_valid = 0;

        // Lookup on empty memory.
        lookup_valid = 1; lookup_addr = 5; lookup_tag = 20'h123;
        @(negedge clk);
        check("lk_accept", lookup_ready, 1);
        check("lk_mem_addr", mem_addr, 5);
        tick();
        lookup_valid = 0;
        @(negedge clk);
        check("lk_rvalid", lookup_rvalid, 1);
        check("lk_miss", lookup_hit, 0);
        check("lk_miss_way", lookup_hit_way, 0);
        tick();

        // Refill into empty set, then hit on it.
        do_refill(5, 20'h123, way);
        check("refill_way0", way, 4'b0001);
        lookup_valid = 1; lookup_addr = 5; lookup_tag = 20'h123;
        tick();
        lookup_valid = 0;
        @(negedge clk);
        check("lk_hit_way0", lookup_hit_way, 4'b0001);
        tick();

        // Five refills to one set: fill invalid ways, then round-robin.
        for (int i = 0; i < 5; i++) begin
            do_refill(7, TW'(20'h10 + i), way);
            check("rr_victim", way, exp_way[i]);
        end

        // Refill beats lookup; lookup accepted three cycles later.
        refill_valid = 1; refill_addr = 9; refill_tag = 20'h55;
        lookup_valid = 1; lookup_addr = 7; lookup_tag = 20'h11;
        @(negedge clk);
        check("prio_refill_ready", refill_ready, 1);
        check("prio_lookup_blocked", lookup_ready, 0);
        tick();
        refill_valid = 0;
        @(negedge clk);
        check("prio_lk_t1", lookup_ready, 0);
        tick();
        @(negedge clk);
        check("prio_lk_t2", lookup_ready, 0);
        tick();
        @(negedge clk);
        check("prio_lk_t3", lookup_ready, 1);
        tick();
        lookup_valid = 0;
        @(negedge clk);
        check("prio_hit_way1", lookup_hit_way, 4'b0010);
        tick();

        // Flush raised during RF_RD: refill finishes, then a 64-set sweep.
        refill_valid = 1; refill_addr = 10; refill_tag = 20'h77;
        lookup_valid = 1; lookup_addr = 7; lookup_tag = 20'h11;
        tick();
        refill_valid = 0; flush = 1;
        tick();
        flush = 0;
        @(negedge clk);
        check("flush_rf_done", refill_done, 1);
        check("flush_rf_busy", flush_busy, 1);
        n = 0; bad = 0;
        while (n < 200) begin
            tick();
            n++;
            @(negedge clk);
            if (lookup_ready) bad++;
            if (flush_done) break;
        end
        check("flush_len", n, 64);
        check("flush_lk_blocked", bad, 0);
        tick();
        @(negedge clk);
        check("post_flush_accept", lookup_ready, 1);
        tick();
        lookup_valid = 0;
        @(negedge clk);
        check("post_flush_rvalid", lookup_rvalid, 1);
        check("post_flush_miss", lookup_hit, 0);
        tick();

        // Reset in the middle of a sweep.
        flush = 1;
        tick();
        flush = 0;
        repeat (20) tick();
        @(negedge clk);
        check("sweep_set20", mem_addr, 20);
        lookup_valid = 1; lookup_addr = 3; lookup_tag = 20'h1;
        #1 rst = 1;
        #1;
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_busy", flush_busy, 0);
        check("rst_lk_ready", lookup_ready, 0);
        @(negedge clk);
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        check("after_rst_accept", lookup_ready, 1);
        check("after_rst_busy", flush_busy, 0);
        tick();
        lookup_valid = 0;

        // Random traffic on a few sets and tags so hits, evictions and flushes mix.
        for (int c = 0; c < 3000; c++) begin
            lookup_valid = ($urandom % 2) == 0;
            lookup_addr  = AW'($urandom % 4);
            lookup_tag   = TW'($urandom % 5);
            refill_valid = ($urandom % 4) == 0;
            refill_addr  = AW'($urandom % 4);
            refill_tag   = TW'($urandom % 5);
            flush        = ($urandom % 150) == 0;
            rst          = ($urandom % 1000) == 0;
            tick();
        end
        lookup_valid = 0; refill_valid = 0; flush = 0; rst = 0;
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
